// File: rtl/leaky_relu_derivative_bank.sv
// N-column leaky-ReLU derivative unit: per-column H FIFO, gradient scaling, registered outputs.
// Optional LRD_SATURATE_EN clamps the leak-path product instead of wrapping it.
module leaky_relu_derivative_bank #(
    parameter int unsigned N_COLS = 2,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned FRAC_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [DATA_W-1:0]                     lr_leak_factor_in,
    input  logic [N_COLS-1:0]                     lr_d_H_valid_in,
    input  logic [N_COLS*DATA_W-1:0]              lr_d_H_in,
    input  logic [N_COLS-1:0]                     lr_d_valid_in,
    input  logic [N_COLS*DATA_W-1:0]              lr_d_data_in,
    input  logic                                  lr_d_err_clr_in,
    output logic [N_COLS*DATA_W-1:0]              lr_d_data_out,
    output logic [N_COLS-1:0]                     lr_d_valid_out,
    output logic [N_COLS*$clog2(DEPTH+1)-1:0]     lr_d_H_count_out,
    output logic [N_COLS-1:0]                     lr_d_overflow_out,
    output logic [N_COLS-1:0]                     lr_d_underflow_out
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned PtrW = $clog2(DEPTH);

    logic signed [DATA_W-1:0] leak;
    assign leak = lr_leak_factor_in;

    for (genvar c = 0; c < N_COLS; c++) begin : g_col
        logic signed [DATA_W-1:0]   h_in;
        logic signed [DATA_W-1:0]   grad_in;
        logic signed [DATA_W-1:0]   sel_h;
        logic signed [DATA_W-1:0]   scaled;
        logic signed [DATA_W-1:0]   data_d;
        logic signed [DATA_W-1:0]   data_q;
        logic signed [DATA_W-1:0]   mem_q [DEPTH];
        logic [PtrW-1:0]            wr_ptr_q, wr_ptr_d;
        logic [PtrW-1:0]            rd_ptr_q, rd_ptr_d;
        logic [CntW-1:0]            count_q, count_d;
        logic                       push_req, pop_req, empty, full;
        logic                       bypass, pop, store;
        logic                       ovf_evt, unf_evt;
        logic                       ovf_q, ovf_d, unf_q, unf_d, valid_q;
        logic signed [2*DATA_W-1:0] prod, shifted;

        assign h_in     = lr_d_H_in[c*DATA_W +: DATA_W];
        assign grad_in  = lr_d_data_in[c*DATA_W +: DATA_W];
        assign push_req = lr_d_H_valid_in[c];
        assign pop_req  = lr_d_valid_in[c];
        assign empty    = (count_q == '0);
        assign full     = (count_q == CntW'(DEPTH));

        always_comb begin
            // Push into an empty FIFO alongside a gradient skips storage entirely.
            bypass   = push_req && pop_req && empty;
            pop      = pop_req && !empty;
            store    = push_req && !bypass && (!full || pop);
            ovf_evt  = push_req && full && !pop;
            unf_evt  = pop_req && empty && !push_req;
            sel_h    = '0;
            if (bypass) begin
                sel_h = h_in;
            end else if (pop) begin
                sel_h = mem_q[rd_ptr_q];
            end
            count_d  = count_q + CntW'(store) - CntW'(pop);
            wr_ptr_d = store ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
            rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
            ovf_d    = (ovf_q & ~lr_d_err_clr_in) | ovf_evt;
            unf_d    = (unf_q & ~lr_d_err_clr_in) | unf_evt;
        end

        always_comb begin
            prod    = $signed({{DATA_W{grad_in[DATA_W-1]}}, grad_in})
                    * $signed({{DATA_W{leak[DATA_W-1]}}, leak});
            shifted = prod >>> FRAC_W;
`ifdef LRD_SATURATE_EN
            if (shifted > $signed({{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}})) begin
                scaled = {1'b0, {(DATA_W-1){1'b1}}};
            end else if (shifted < $signed({{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}})) begin
                scaled = {1'b1, {(DATA_W-1){1'b0}}};
            end else begin
                scaled = shifted[DATA_W-1:0];
            end
`else
            scaled = shifted[DATA_W-1:0];
`endif
            data_d = (!sel_h[DATA_W-1] && (sel_h != '0)) ? grad_in : scaled;
        end

`ifndef LRD_SATURATE_EN
        logic unused_shift_hi;
        assign unused_shift_hi = ^shifted[2*DATA_W-1:DATA_W];
`endif

        always_ff @(posedge clk) begin
            if (rst && store) begin
                mem_q[wr_ptr_q] <= h_in;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                ovf_q    <= 1'b0;
                unf_q    <= 1'b0;
                valid_q  <= 1'b0;
                data_q   <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
                ovf_q    <= ovf_d;
                unf_q    <= unf_d;
                valid_q  <= pop_req;
                if (pop_req) begin
                    data_q <= data_d;
                end
            end
        end

        assign lr_d_data_out[c*DATA_W +: DATA_W]  = data_q;
        assign lr_d_valid_out[c]                  = valid_q;
        assign lr_d_H_count_out[c*CntW +: CntW]   = count_q;
        assign lr_d_overflow_out[c]               = ovf_q;
        assign lr_d_underflow_out[c]              = unf_q;
    end

endmodule

// File: tb/tb_leaky_relu_derivative_bank.sv
// Bench for leaky_relu_derivative_bank: directed scenarios plus random traffic vs a queue model.
module tb_leaky_relu_derivative_bank;

    localparam int N_COLS = 2;
    localparam int DATA_W = 16;
    localparam int FRAC_W = 8;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH + 1);

    logic                       clk = 1'b0;
    logic                       rst;
    logic [DATA_W-1:0]          leak;
    logic [N_COLS-1:0]          hv, gv;
    logic [N_COLS*DATA_W-1:0]   h, g;
    logic                       clr;
    logic [N_COLS*DATA_W-1:0]   d_out;
    logic [N_COLS-1:0]          v_out;
    logic [N_COLS*CW-1:0]       cnt_out;
    logic [N_COLS-1:0]          ovf_out, unf_out;

    int n_cmp = 0;
    int n_err = 0;

    logic [DATA_W-1:0] mq [N_COLS][$];
    logic [DATA_W-1:0] m_data [N_COLS];
    logic [N_COLS-1:0] m_valid, m_ovf, m_unf;

    leaky_relu_derivative_bank #(
        .N_COLS(N_COLS), .DATA_W(DATA_W), .FRAC_W(FRAC_W), .DEPTH(DEPTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .lr_leak_factor_in (leak),
        .lr_d_H_valid_in   (hv),
        .lr_d_H_in         (h),
        .lr_d_valid_in     (gv),
        .lr_d_data_in      (g),
        .lr_d_err_clr_in   (clr),
        .lr_d_data_out     (d_out),
        .lr_d_valid_out    (v_out),
        .lr_d_H_count_out  (cnt_out),
        .lr_d_overflow_out (ovf_out),
        .lr_d_underflow_out(unf_out)
    );

    always #5 clk = ~clk;

    // Reference scaling from plain integer arithmetic.
    function automatic logic [DATA_W-1:0] scale(input logic [DATA_W-1:0] grad,
                                                input logic [DATA_W-1:0] lk,
                                                input logic [DATA_W-1:0] hh);
        longint p;
        longint maxv;
        longint minv;
        if ($signed(hh) > 0) return grad;
        maxv = (longint'(1) <<< (DATA_W - 1)) - 1;
        minv = -(longint'(1) <<< (DATA_W - 1));
        p = longint'($signed(grad)) * longint'($signed(lk));
        p = p >>> FRAC_W;
`ifdef LRD_SATURATE_EN
        if (p > maxv) p = maxv;
        else if (p < minv) p = minv;
`else
        if (p > maxv || p < minv) p = p;
`endif
        return p[DATA_W-1:0];
    endfunction

    // Drive one clock of stimulus and advance the model alongside it.
    task automatic cycle(input logic r, input logic [N_COLS-1:0] hvi,
                         input logic [N_COLS*DATA_W-1:0] hi, input logic [N_COLS-1:0] gvi,
                         input logic [N_COLS*DATA_W-1:0] gi, input logic [DATA_W-1:0] lk,
                         input logic cl);
        logic [N_COLS-1:0] ovf_e, unf_e;
        rst = r; hv = hvi; h = hi; gv = gvi; g = gi; leak = lk; clr = cl;
        @(posedge clk);
        ovf_e = '0;
        unf_e = '0;
        if (!r) begin
            for (int c = 0; c < N_COLS; c++) begin
                mq[c].delete();
                m_data[c] = '0;
            end
            m_valid = '0; m_ovf = '0; m_unf = '0;
        end else begin
            for (int c = 0; c < N_COLS; c++) begin
                logic [DATA_W-1:0] hc;
                logic [DATA_W-1:0] sel;
                logic              byp;
                hc  = hi[c*DATA_W +: DATA_W];
                sel = '0;
                byp = 1'b0;
                if (gvi[c]) begin
                    if (mq[c].size() > 0) sel = mq[c].pop_front();
                    else if (hvi[c]) begin sel = hc; byp = 1'b1; end
                    else unf_e[c] = 1'b1;
                    m_data[c] = scale(gi[c*DATA_W +: DATA_W], lk, sel);
                end
                if (hvi[c] && !byp) begin
                    if (mq[c].size() < DEPTH) mq[c].push_back(hc);
                    else ovf_e[c] = 1'b1;
                end
            end
            m_valid = gvi;
            m_ovf   = (m_ovf & ~{N_COLS{cl}}) | ovf_e;
            m_unf   = (m_unf & ~{N_COLS{cl}}) | unf_e;
        end
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b0, 2'b11, 32'h1234_5678, 2'b11, 32'h1111_2222, 16'h0080, 1'b0);
        cycle(1'b0, 2'b11, 32'h1234_5678, 2'b11, 32'h1111_2222, 16'h0080, 1'b0);
        n_cmp++; if (d_out !== '0) begin n_err++;
            $display("FAIL reset_data got=%h want=0", d_out); end
        n_cmp++; if (v_out !== '0) begin n_err++;
            $display("FAIL reset_valid got=%b want=0", v_out); end
        n_cmp++; if (cnt_out !== '0) begin n_err++;
            $display("FAIL reset_count got=%h want=0", cnt_out); end
        n_cmp++; if ({ovf_out, unf_out} !== '0) begin n_err++;
            $display("FAIL reset_sticky got=%b%b want=0", ovf_out, unf_out); end
    endtask

    task automatic test_basic();
        cycle(1'b0, '0, '0, '0, '0, '0, 1'b0);
        cycle(1'b1, 2'b11, {16'h0100, 16'hFF00}, 2'b00, '0, 16'h0080, 1'b0);
        cycle(1'b1, 2'b00, '0, 2'b11, {16'h0200, 16'h0200}, 16'h0080, 1'b0);
        n_cmp++; if (d_out !== 32'h0200_0100) begin n_err++;
            $display("FAIL basic_data got=%h want=02000100", d_out); end
        n_cmp++; if (v_out !== 2'b11) begin n_err++;
            $display("FAIL basic_valid got=%b want=11", v_out); end
        n_cmp++; if (cnt_out !== '0) begin n_err++;
            $display("FAIL basic_count got=%h want=0", cnt_out); end
    endtask

    task automatic test_fifo_order();
        logic [DATA_W-1:0] lk;
        cycle(1'b0, '0, '0, '0, '0, '0, 1'b0);
        lk = DATA_W'($urandom_range(1, 16'h0100));
        for (int i = 0; i < 8; i++) begin
            logic [DATA_W-1:0] hval;
            logic [DATA_W-1:0] gval;
            logic              push;
            logic              popr;
            hval = DATA_W'($urandom_range(1, 16'h3FFF));
            if (i % 2 == 1) hval = -hval;
            gval = DATA_W'($urandom_range(0, 16'h0FFF));
            push = (i < 6);
            popr = (i >= 6) || (i % 3 != 0);
            cycle(1'b1, {1'b0, push}, {16'h0000, hval}, {1'b0, popr}, {16'h0000, gval}, lk, 1'b0);
            n_cmp++; if (cnt_out[CW-1:0] > CW'(DEPTH) || cnt_out[CW-1:0] !== CW'(mq[0].size()))
                begin n_err++;
                $display("FAIL fifo_count[%0d] got=%0d want=%0d", i, cnt_out[CW-1:0],
                         mq[0].size()); end
            if (popr) begin
                n_cmp++; if (d_out[DATA_W-1:0] !== m_data[0]) begin n_err++;
                    $display("FAIL fifo_data[%0d] got=%h want=%h", i, d_out[DATA_W-1:0],
                             m_data[0]); end
            end
        end
        n_cmp++; if (cnt_out !== '0 || {ovf_out, unf_out} !== '0) begin n_err++;
            $display("FAIL fifo_end cnt=%h err=%b%b want=0", cnt_out, ovf_out, unf_out); end
    endtask

    task automatic test_full();
        cycle(1'b0, '0, '0, '0, '0, '0, 1'b0);
        cycle(1'b1, 2'b10, {16'hFE00, 16'h0000}, '0, '0, 16'h0080, 1'b0);
        for (int i = 1; i < 5; i++)
            cycle(1'b1, 2'b10, {DATA_W'(i * 16'h0100), 16'h0000}, '0, '0, 16'h0080, 1'b0);
        n_cmp++; if (cnt_out[CW +: CW] !== CW'(4)) begin n_err++;
            $display("FAIL full_count got=%0d want=4", cnt_out[CW +: CW]); end
        n_cmp++; if (ovf_out !== 2'b10) begin n_err++;
            $display("FAIL full_overflow got=%b want=10", ovf_out); end
        cycle(1'b1, 2'b10, {16'h0700, 16'h0000}, 2'b10, {16'h0300, 16'h0000}, 16'h0080, 1'b0);
        n_cmp++; if (cnt_out[CW +: CW] !== CW'(4)) begin n_err++;
            $display("FAIL full_pushpop_count got=%0d want=4", cnt_out[CW +: CW]); end
        n_cmp++; if (d_out[DATA_W +: DATA_W] !== 16'h0180) begin n_err++;
            $display("FAIL full_pushpop_data got=%h want=0180", d_out[DATA_W +: DATA_W]); end
    endtask

    task automatic test_empty();
        cycle(1'b0, '0, '0, '0, '0, '0, 1'b0);
        cycle(1'b1, '0, '0, 2'b01, {16'h0000, 16'h0400}, 16'h0080, 1'b0);
        n_cmp++; if (d_out[DATA_W-1:0] !== 16'h0200) begin n_err++;
            $display("FAIL empty_data got=%h want=0200", d_out[DATA_W-1:0]); end
        n_cmp++; if (unf_out !== 2'b01) begin n_err++;
            $display("FAIL empty_underflow got=%b want=01", unf_out); end
        cycle(1'b1, 2'b01, {16'h0000, 16'h0100}, 2'b01, {16'h0000, 16'h0400}, 16'h0080, 1'b0);
        n_cmp++; if (d_out[DATA_W-1:0] !== 16'h0400 || cnt_out !== '0) begin n_err++;
            $display("FAIL bypass got=%h cnt=%h want=0400 cnt=0", d_out[DATA_W-1:0], cnt_out); end
        cycle(1'b1, '0, '0, '0, '0, 16'h0080, 1'b1);
        n_cmp++; if (unf_out !== 2'b00) begin n_err++;
            $display("FAIL err_clr got=%b want=00", unf_out); end
    endtask

    task automatic test_saturation();
        logic [DATA_W-1:0] want;
`ifdef LRD_SATURATE_EN
        want = 16'h7FFF;
`else
        want = 16'hFFFE;
`endif
        cycle(1'b0, '0, '0, '0, '0, '0, 1'b0);
        cycle(1'b1, 2'b11, {16'hFF00, 16'hFF00}, '0, '0, 16'h0200, 1'b0);
        cycle(1'b1, '0, '0, 2'b11, {16'h8000, 16'h7FFF}, 16'h0200, 1'b0);
        n_cmp++; if (d_out[DATA_W-1:0] !== want) begin n_err++;
            $display("FAIL sat_pos got=%h want=%h", d_out[DATA_W-1:0], want); end
        n_cmp++; if (d_out[DATA_W +: DATA_W] !== m_data[1]) begin n_err++;
            $display("FAIL sat_neg got=%h want=%h", d_out[DATA_W +: DATA_W], m_data[1]); end
    endtask

    task automatic test_reset_mid();
        cycle(1'b0, '0, '0, '0, '0, '0, 1'b0);
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 2'b01, {16'h0000, DATA_W'(16'h0100 + i)}, 2'b10, 32'h0123_0000,
                  16'h0080, 1'b0);
        cycle(1'b0, 2'b11, 32'h0055_0066, 2'b11, 32'h0077_0088, 16'h0080, 1'b0);
        n_cmp++; if (cnt_out !== '0 || v_out !== '0 || d_out !== '0) begin n_err++;
            $display("FAIL midreset cnt=%h valid=%b data=%h want=0", cnt_out, v_out, d_out); end
        n_cmp++; if ({ovf_out, unf_out} !== '0) begin n_err++;
            $display("FAIL midreset_sticky got=%b%b want=0", ovf_out, unf_out); end
        cycle(1'b1, '0, '0, 2'b01, {16'h0000, 16'h0400}, 16'h0080, 1'b0);
        n_cmp++; if (unf_out !== 2'b01) begin n_err++;
            $display("FAIL midreset_underflow got=%b want=01", unf_out); end
    endtask

    task automatic test_random();
        cycle(1'b0, '0, '0, '0, '0, '0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 63) != 0), N_COLS'($urandom), {$urandom},
                  N_COLS'($urandom), {$urandom}, DATA_W'($urandom),
                  ($urandom_range(0, 15) == 0));
            for (int c = 0; c < N_COLS; c++) begin
                n_cmp++; if (d_out[c*DATA_W +: DATA_W] !== m_data[c]) begin n_err++;
                    $display("FAIL rand_data[%0d] col%0d got=%h want=%h", i, c,
                             d_out[c*DATA_W +: DATA_W], m_data[c]); end
                n_cmp++; if (cnt_out[c*CW +: CW] !== CW'(mq[c].size())) begin n_err++;
                    $display("FAIL rand_count[%0d] col%0d got=%0d want=%0d", i, c,
                             cnt_out[c*CW +: CW], mq[c].size()); end
            end
            n_cmp++; if (v_out !== m_valid || ovf_out !== m_ovf || unf_out !== m_unf) begin
                n_err++;
                $display("FAIL rand_status[%0d] got=%b/%b/%b want=%b/%b/%b", i, v_out, ovf_out,
                         unf_out, m_valid, m_ovf, m_unf); end
        end
    endtask

    initial begin
        rst = 1'b0; hv = '0; h = '0; gv = '0; g = '0; leak = '0; clr = 1'b0;
        test_reset();
        test_basic();
        test_fifo_order();
        test_full();
        test_empty();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/leaky_relu_derivative_bank.md
Name: leaky_relu_derivative_bank

Overview:
- N-column leaky-ReLU derivative unit for the backward pass; replaces the fixed 2-column parent.
- Each column owns a DEPTH-entry FIFO that captures forward-pass pre-activations (H) as they stream out of the systolic array.
- During backprop, each incoming gradient pops its matching H and is scaled by 1 (H>0) or by the leak factor (H<=0).
- Output is registered, with per-column valid, occupancy and sticky error status.

Parameters:
- N_COLS, 2, number of independent columns.
- DATA_W, 16, signed width of H, gradient, leak and output.
- FRAC_W, 8, fractional bits of the fixed-point format (Q(DATA_W-FRAC_W).FRAC_W).
- DEPTH, 4, H FIFO entries per column; power of two, >=2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-low reset (0 = reset).
- lr_leak_factor_in  in  DATA_W  signed leak factor, shared by all columns; sampled each cycle.
- lr_d_H_valid_in  in  N_COLS  per-column H push strobe.
- lr_d_H_in  in  N_COLS*DATA_W  H data; column c at bits [c*DATA_W +: DATA_W].
- lr_d_valid_in  in  N_COLS  per-column gradient valid (pop request).
- lr_d_data_in  in  N_COLS*DATA_W  gradient data, same packing.
- lr_d_err_clr_in  in  1  clears all sticky error bits.
- lr_d_data_out  out  N_COLS*DATA_W  scaled gradient.
- lr_d_valid_out  out  N_COLS  per-column output valid.
- lr_d_H_count_out  out  N_COLS*$clog2(DEPTH+1)  per-column FIFO occupancy.
- lr_d_overflow_out  out  N_COLS  sticky: push dropped because FIFO full.
- lr_d_underflow_out  out  N_COLS  sticky: gradient arrived with no H available.

Behaviour:
- Reset (rst==0 at a clock edge): all outputs 0, all FIFO pointers and counts 0, sticky bits 0. Reset mid-stream discards stored H and any in-flight output.
- Columns are fully independent; column c sees only bit c of each strobe.
- FIFO:
  - Push when lr_d_H_valid_in[c].
  - Pop when lr_d_valid_in[c] and (count>0 or bypass).
  - Pointers wrap modulo DEPTH.
  - count = count + push_accepted - pop.
- Simultaneous push and pop:
  - count>0: both occur, count unchanged, popped value is the oldest entry.
  - count==0: bypass; the incoming H is used directly, nothing is stored, count stays 0.
- Full (count==DEPTH):
  - Push without pop: H dropped, overflow[c] set.
  - Push with pop: both occur, count stays DEPTH.
- Empty, gradient valid, no push: underflow[c] set; H treated as 0 (leak path); output still produced.
- Scaling:
  - sel_H > 0: out = gradient unchanged.
  - sel_H <= 0: prod = gradient * leak (2*DATA_W signed), then arithmetic shift right by FRAC_W (truncate toward -inf), then reduced to DATA_W (see optional feature).
- Latency: exactly 1 cycle.
  - lr_d_valid_out[c] is the registered lr_d_valid_in[c].
  - lr_d_data_out[c] is updated only when valid_in[c]=1; otherwise it holds its previous value.
- No backpressure: the consumer must accept every valid output.
- Status:
  - lr_d_H_count_out is registered and reflects state after the current edge.
  - Sticky bits clear on lr_d_err_clr_in. If a clear and a new error occur in the same cycle, the new error wins (bit stays 1).
- Leak factor is not latched; changing it mid-stream affects the next computed sample.

Optional Feature:
- LRD_SATURATE_EN:
  - Defined: shifted product clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Undefined: shifted product is truncated to its low DATA_W bits (two's-complement wrap).
  - The pass-through path (H>0) is unaffected either way.

Test Plan (DATA_W=16, FRAC_W=8, DEPTH=4, N_COLS=2):
- Basic leak and pass:
  - Push H=0xFF00 (-1.0) to col0 and H=0x0100 to col1; next cycle gradient 0x0200 on both with leak=0x0080.
  - Expect 1 cycle later: col0=0x0100, col1=0x0200, valid_out=2'b11, counts=0.
- FIFO order and wrap:
  - Push 6 H values to col0 alternating sign (+,-,+,-,+,-), interleaved with 6 pops (two pops per three pushes, then drain).
  - Expect outputs follow FIFO order through the pointer wrap; count never exceeds 4; no error bits set.
- Full boundary:
  - Push 5 H to col1 with no pops. Expect count=4, overflow=2'b10.
  - Then push+pop in the same cycle. Expect count stays 4 and the oldest entry is used.
- Empty boundary:
  - Gradient 0x0400 on col0 with empty FIFO and no push, leak=0x0080. Expect out=0x0200, underflow=2'b01.
  - Simultaneous push H=0x0100 + gradient. Expect bypass: out=gradient, count=0.
  - err_clr clears underflow.
- Saturation:
  - H=0xFF00, gradient=0x7FFF, leak=0x0200.
  - Expect 0x7FFF with LRD_SATURATE_EN, 0xFFFE without.
- Reset mid-operation:
  - Fill col0 with 3 entries, drive rst=0 for one cycle.
  - Expect counts, valid_out, data_out and sticky bits all 0 on the next cycle; a subsequent gradient flags underflow.
